// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through/write-allocate data cache controller driving an external 1-cycle BRAM.
// Define DCACHE_STAT_EN to add the hit_cnt/miss_cnt read statistics outputs.
module dcache_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                   clka,
    input  logic                   rsta,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_WIDTH-1:0]  cpu_addr,
    input  logic [DATA_WIDTH-1:0]  cpu_wdata,
    input  logic                   cpu_flush,
    output logic [DATA_WIDTH-1:0]  cpu_rdata,
    output logic                   cpu_ready,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_ack,
    output logic [INDEX_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0]  bram_din,
    output logic                   bram_we,
    output logic                   bram_en,
    input  logic [DATA_WIDTH-1:0]  bram_dout
`ifdef DCACHE_STAT_EN
    ,
    output logic [31:0]            hit_cnt,
    output logic [31:0]            miss_cnt
`endif
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
    localparam int DEPTH     = 2 ** INDEX_WIDTH;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, WRITE} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-3:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [TAG_WIDTH-1:0]    tags [DEPTH];
    logic [DEPTH-1:0]        valid;
    logic [INDEX_WIDTH-1:0]  index_q;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic                    accept, hit, done;
    logic                    unused_addr_bits;

    assign index_q          = addr_q[INDEX_WIDTH-1:0];
    assign tag_q            = addr_q[ADDR_WIDTH-3:INDEX_WIDTH];
    assign accept           = state == IDLE && cpu_req && !cpu_ready;
    assign hit              = valid[index_q] && tags[index_q] == tag_q;
    assign done             = mem_req && mem_ack;
    assign unused_addr_bits = ^cpu_addr[1:0];

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) state <= IDLE;
        else      state <= state_next;
    end

    // BRAM strobes are gated by reset so nothing reaches the array while rsta is high.
    always_comb begin
        state_next = state;
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = index_q;
        bram_din   = state == WRITE ? wdata_q : mem_rdata;
        case (state)
            IDLE: if (accept) begin
                state_next = cpu_we ? WRITE : LOOKUP;
                bram_en    = !cpu_we && !rsta;
                bram_addr  = cpu_addr[INDEX_WIDTH+1:2];
            end
            LOOKUP: state_next = hit ? IDLE : REFILL;
            REFILL, WRITE: if (done) begin
                state_next = IDLE;
                bram_en    = !rsta;
                bram_we    = !rsta;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (bram_we) tags[index_q] <= tag_q;
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            valid     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    addr_q    <= cpu_addr[ADDR_WIDTH-1:2];
                    wdata_q   <= cpu_wdata;
                    mem_addr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_wdata <= cpu_wdata;
                    mem_req   <= cpu_we;
                    mem_we    <= cpu_we;
                end else if (!cpu_req && cpu_flush) begin
                    valid <= '0;
                end
                LOOKUP: begin
                    cpu_ready <= hit;
                    cpu_rdata <= hit ? bram_dout : cpu_rdata;
                    mem_req   <= !hit;
                    mem_we    <= 1'b0;
                end
                REFILL: if (done) begin
                    cpu_rdata      <= mem_rdata;
                    cpu_ready      <= 1'b1;
                    mem_req        <= 1'b0;
                    valid[index_q] <= 1'b1;
                end
                WRITE: if (done) begin
                    cpu_ready      <= 1'b1;
                    mem_req        <= 1'b0;
                    mem_we         <= 1'b0;
                    valid[index_q] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DCACHE_STAT_EN
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            hit_cnt  <= hit_cnt + 32'(hit);
            miss_cnt <= miss_cnt + 32'(!hit);
        end
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench with a BRAM model, a randomly delayed memory responder and a reference cache model.
module tb_dcache_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_flush = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        cpu_ready, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  bram_addr;
    logic [31:0] bram_din, bram_dout;
    logic        bram_we, bram_en;
`ifdef DCACHE_STAT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    dcache_ctrl dut (
        .clka(clk), .rsta(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_flush(cpu_flush), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_we(bram_we), .bram_en(bram_en), .bram_dout(bram_dout)
`ifdef DCACHE_STAT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Single-port no-change BRAM: dout holds its value on write cycles.
    logic [31:0] bram [256];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) bram[bram_addr] <= bram_din;
            else         bram_dout <= bram[bram_addr];
        end
    end

    typedef struct {
        logic        we;
        logic        hit;
        logic [31:0] rdata;
        time         t;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0, miscompares = 0;
    logic [31:0] ref_mem [logic [31:0]];
    bit          rv [256];
    logic [21:0] rt [256];
    int          r_hits = 0, r_miss = 0;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    logic        cur_we = 1'b0, hold_ack = 1'b0, late_ack = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return ref_mem.exists(w) ? ref_mem[w] : (w * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 256; i++) rv[i] = 1'b0;
    endtask

    // Scoreboard monitor: pops one expectation per cpu_ready pulse.
    initial begin
        exp_t e;
        bit   mem_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) mem_seen = 1'b0;
            else begin
                if (mem_req) mem_seen = 1'b1;
                if (cpu_ready) begin
                    if (exp_q.size() == 0) chk("spurious_ready", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("mem_access", 32'(mem_seen), 32'(!e.hit));
                        if (!e.we) chk("rdata", cpu_rdata, e.rdata);
                        if (!e.we && e.hit) chk("hit_latency", 32'(($time - e.t) / 10), 32'd2);
                    end
                    mem_seen = 1'b0;
                end
            end
        end
    end

    // Memory responder with 0..3 cycles of ack delay.
    initial begin
        int wl = -1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (rst) wl = -1;
            if (late_ack) mem_ack = 1'b1;
            else if (mem_req && !rst && !hold_ack) begin
                if (wl < 0) wl = $urandom_range(0, 3);
                if (wl == 0) begin
                    chk("mem_addr", mem_addr, {cur_addr[31:2], 2'b00});
                    chk("mem_we", 32'(mem_we), 32'(cur_we));
                    if (cur_we) chk("mem_wdata", mem_wdata, cur_wdata);
                    else mem_rdata = mem_rd(mem_addr);
                    mem_ack = 1'b1;
                    wl = -1;
                end else wl--;
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic fl);
        exp_t e;
        logic h;
        h = rv[a[9:2]] && rt[a[9:2]] == a[31:10];
        e.we = we;
        e.hit = !we && h;
        e.rdata = mem_rd(a);
        e.t = $time;
        if (!we) begin
            if (h) r_hits++;
            else   r_miss++;
        end
        if (we) ref_mem[{a[31:2], 2'b00}] = d;
        rv[a[9:2]] = 1'b1;
        rt[a[9:2]] = a[31:10];
        exp_q.push_back(e);
        cur_addr = a; cur_we = we; cur_wdata = d;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_flush = fl;
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic fl);
        bit got = 1'b0;
        @(negedge clk);
        issue(we, a, d, fl);
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            cpu_flush = 1'b0;
            got = cpu_ready;
        end
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
        if (!got) begin
            chk("ready_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    task automatic do_flush();
        @(negedge clk);
        cpu_flush = 1'b1;
        @(negedge clk);
        cpu_flush = 1'b0;
        ref_reset();
    endtask

    task automatic chk_stats();
`ifdef DCACHE_STAT_EN
        chk("hit_cnt", hit_cnt, 32'(r_hits));
        chk("miss_cnt", miss_cnt, 32'(r_miss));
`endif
    endtask

    initial begin
        ref_reset();
        repeat (3) @(negedge clk);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_bram_en", 32'(bram_en), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        ref_mem[32'h010] = 32'hDEADBEEF;
        do_req(1'b0, 32'h010, 32'h0, 1'b0);
        chk("bram_idx4", bram[4], 32'hDEADBEEF);
        do_req(1'b0, 32'h010, 32'h0, 1'b0);
        ref_mem[32'h410] = 32'h0BADF00D;
        do_req(1'b0, 32'h410, 32'h0, 1'b0);
        do_req(1'b0, 32'h010, 32'h0, 1'b0);
        do_req(1'b1, 32'h020, 32'h12345678, 1'b0);
        do_req(1'b0, 32'h020, 32'h0, 1'b0);
        do_flush();
        do_req(1'b0, 32'h020, 32'h0, 1'b0);
        chk_stats();

        // Reset while a refill is waiting for its ack.
        hold_ack = 1'b1;
        @(negedge clk);
        issue(1'b0, 32'h010, 32'h0, 1'b0);
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        chk("refill_mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_drop_mem_req", 32'(mem_req), 32'd0);
        chk("rst_no_ready", 32'(cpu_ready), 32'd0);
        cpu_req = 1'b0;
        exp_q.delete();
        ref_reset();
        r_hits = 0;
        r_miss = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold_ack = 1'b0;
        late_ack = 1'b1;
        repeat (2) @(negedge clk);
        late_ack = 1'b0;
        repeat (3) @(negedge clk);
        do_req(1'b0, 32'h010, 32'h0, 1'b0);
        chk_stats();

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) do_flush();
            else do_req($urandom_range(0, 2) == 0,
                        32'($urandom_range(0, 3) << 10) | 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3)),
                        $urandom, $urandom_range(0, 7) == 0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
